// File: rtl/seq_mult_n_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier family.
package seq_mult_n_pkg;

    localparam int DEFAULT_N = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_mult_adder.sv
// Parametrised ripple-carry adder used as the multiplier's accumulation adder.
module seq_mult_adder
    import seq_mult_n_pkg::*;
#(
    parameter int W = 2 * DEFAULT_N
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic carry;

    // NOTE: blocking assignments here so carry ripples bit to bit within one evaluation;
    // every output gets a default first so no latch is inferred.
    always_comb begin
        sum_o = '0;
        carry = cin_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/seq_mult_n.sv
// Sequential N x N shift-and-add multiplier, unsigned or two's-complement,
// computing on magnitudes and fixing the sign in a final cycle.
module seq_mult_n
    import seq_mult_n_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int W  = 2 * N;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    function automatic logic [W-1:0] negate(input logic [W-1:0] v);
        return ~v + W'(1);
    endfunction

    state_e       state_q;
    logic         busy_q, done_q, mode_q, neg_q;
    logic [N-1:0] mplier_q;
    logic [W-1:0] mcand_q, acc_q, product_q;
    logic [CW-1:0] count_q;

    logic [W-1:0] a_neg, b_neg, acc_d, product_d;
    logic         adder_cout;
    logic         unused_ok;

    // Sign-extending before negation makes |-2^(N-1)| come out right in the low N bits.
    assign a_neg     = negate({{N{a[N-1]}}, a});
    assign b_neg     = negate({{N{b[N-1]}}, b});
    assign product_d = (mode_q & neg_q) ? negate(acc_q) : acc_q;
    assign unused_ok = ^{a_neg[W-1:N], adder_cout};

    seq_mult_adder #(.W(W)) u_adder (
        .a_i   (acc_q),
        .b_i   (mcand_q),
        .cin_i (1'b0),
        .sum_o (acc_d),
        .cout_o(adder_cout)
    );

    // NOTE: non-blocking assignments for all registered state so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= 1'b0;
            neg_q     <= 1'b0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q   <= signed_mode;
                        neg_q    <= signed_mode & (a[N-1] ^ b[N-1]);
                        mplier_q <= (signed_mode && a[N-1]) ? a_neg[N-1:0] : a;
                        mcand_q  <= (signed_mode && b[N-1]) ? b_neg : {{N{1'b0}}, b};
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (mplier_q[count_q[IW-1:0]]) begin
                        acc_q <= acc_d;
                    end
                    mcand_q <= mcand_q << 1;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(N - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    product_q <= product_d;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/seq_mult_n.md
SEQ_MULT_N -- requirements
Module: seq_mult_n

Interface
REQ-001 The block SHALL have parameter N, default 6, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CW, default $clog2(N)+1, giving the bit-counter width.
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 rst  input  1  Reset, asynchronous and active-high.
REQ-005 start  input  1  Request pulse; operands and mode are sampled on the rising edge where start=1 is accepted.
REQ-006 signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned.
REQ-007 a  input  N  Multiplier operand.
REQ-008 b  input  N  Multiplicand operand.
REQ-009 busy  output  1  High from the edge after acceptance until done rises.
REQ-010 done  output  1  Single-cycle pulse marking product valid.
REQ-011 product  output  2N  Result; holds its value until the next accepted start.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, FIX and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE, and SHALL be ignored in BUSY and FIX.
REQ-014 On acceptance, the block SHALL latch signed_mode, the operand magnitudes |a| and |b| (raw values when unsigned), and neg = signed_mode & (a[N-1]^b[N-1]); it SHALL clear the accumulator and count, then enter BUSY.
REQ-015 In BUSY, each edge SHALL add the multiplicand register to the 2N-bit accumulator if the multiplier bit indexed by count is 1, shift the multiplicand register left by 1, and increment count.
REQ-016 After exactly N BUSY edges (count reaches N), the FSM SHALL enter FIX.
REQ-017 In FIX, product SHALL be loaded with neg ? two's-complement negation of the accumulator : the accumulator, and the FSM SHALL enter DONE.
REQ-018 done SHALL be 1 only while in DONE, which lasts one cycle; the FSM SHALL then go to IDLE, or to BUSY if start=1.
REQ-019 Latency SHALL be fixed: done is high during the cycle following the (N+2)th rising edge counted from the accepting edge inclusive.
REQ-020 In unsigned mode, arithmetic SHALL be exact over 2N bits with no overflow; the carry out of the adder is discarded.
REQ-021 In signed mode, a = -2^(N-1) SHALL be handled correctly: its magnitude fits in N bits unsigned, and the 2N-bit signed product is exact.
REQ-022 A zero operand SHALL still take full latency, and SHALL yield product = 0 with no negative-zero artefact.
REQ-023 Changes to a, b or signed_mode after acceptance SHALL NOT affect the in-flight result.
REQ-024 product SHALL NOT change in IDLE, BUSY or DONE; it updates only on the FIX edge.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force the state to IDLE, busy=0, done=0, product=0, accumulator=0 and count=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first accepted start after release SHALL behave as from power-up.
REQ-027 start arriving on the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-028 The state encodings (2-bit: IDLE=0, BUSY=1, FIX=2, DONE=3) SHALL live in the team's shared multiplier package/include file alongside the default N.
REQ-029 The 2N-bit accumulation adder SHALL be one sub-module, seq_mult_adder (parametrised ripple-carry, cin tied 0), instantiated once.
REQ-030 Magnitude extraction and final negation SHALL reuse a single negate function/expression, not separate adders per operand.

Verification (N=6)
REQ-031 Unsigned: a=63, b=63, signed_mode=0, start pulse -> done after N+2 edges with product=12'hF81 (3969); busy high for the preceding cycles.
REQ-032 Signed: a=-32, b=-32 -> product=12'h400 (1024); a=-1, b=5 -> product=12'hFFB (-5).
REQ-033 Zero: a=0, b=-17, signed_mode=1 -> product=0, done at the same latency as other cases.
REQ-034 Busy lockout: start with a=3, b=4, then start again two cycles later with a=7, b=7 -> exactly one done, product=12; the second start is ignored.
REQ-035 Back-to-back: start held high on the DONE cycle with a=2, b=9 -> first product valid, next done exactly N+1 edges later with product=18.
REQ-036 Reset abort: rst pulsed mid-BUSY, asynchronously between edges -> outputs 0 immediately, no done; a subsequent a=5, b=6 yields 30.
